// File: rtl/moving_avg_filter.sv
// N-tap moving-average filter (N = 2**LOG2_TAPS) over signed samples, using a running-sum
// accumulator and a circular history buffer. Output is registered with a one-cycle valid pulse.
module moving_avg_filter #(
  parameter int unsigned DATA_W    = 19,
  parameter int unsigned LOG2_TAPS = 1,
  parameter int unsigned ROUND     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              primed
);

  localparam int unsigned Taps   = 1 << LOG2_TAPS;
  localparam int unsigned AccW   = DATA_W + LOG2_TAPS;
  localparam int unsigned RndVal = (ROUND != 0) ? (1 << (LOG2_TAPS - 1)) : 0;
  localparam logic [LOG2_TAPS:0] FillMax = (LOG2_TAPS + 1)'(Taps);

  logic [DATA_W-1:0]    hist_q [Taps];
  logic [LOG2_TAPS-1:0] wr_ptr_q;
  logic [LOG2_TAPS:0]   fill_q, fill_d;
  logic [AccW-1:0]      acc_q, acc_d;
  logic [DATA_W-1:0]    oldest;
  logic signed [AccW:0] rnd_sum;
  logic [DATA_W-1:0]    avg;

  always_comb begin
    oldest  = hist_q[wr_ptr_q];
    // Sign-extend both operands; the sum of TAPS samples always fits in AccW bits.
    acc_d   = acc_q + {{LOG2_TAPS{data_in[DATA_W-1]}}, data_in}
                    - {{LOG2_TAPS{oldest[DATA_W-1]}}, oldest};
    rnd_sum = $signed({acc_d[AccW-1], acc_d}) + $signed((AccW + 1)'(RndVal));
    avg     = DATA_W'(rnd_sum >>> LOG2_TAPS);
    fill_d  = (fill_q == FillMax) ? fill_q : fill_q + (LOG2_TAPS + 1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(Taps); i++) hist_q[i] <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      primed    <= 1'b0;
    end else if (clear) begin
      // Flush history but keep the last output visible downstream.
      for (int i = 0; i < int'(Taps); i++) hist_q[i] <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
    end else if (in_valid) begin
      hist_q[wr_ptr_q] <= data_in;
      wr_ptr_q  <= wr_ptr_q + LOG2_TAPS'(1);
      fill_q    <= fill_d;
      acc_q     <= acc_d;
      out_valid <= 1'b1;
      data_out  <= avg;
      primed    <= (fill_d == FillMax);
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed bench for moving_avg_filter: four instances cover 2-tap truncate/round,
// 4-tap and 8-tap configurations, all driven from one shared stimulus sequence.
module tb_moving_avg_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [18:0] data_in = '0;

  logic              v2, v2r, v4, v8;
  logic signed [18:0] o2, o2r, o4, o8;
  logic              p2, p2r, p4, p8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  moving_avg_filter #(.DATA_W(19), .LOG2_TAPS(1), .ROUND(0)) u_d2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .data_in(data_in),
    .out_valid(v2), .data_out(o2), .primed(p2));
  moving_avg_filter #(.DATA_W(19), .LOG2_TAPS(1), .ROUND(1)) u_d2r (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .data_in(data_in),
    .out_valid(v2r), .data_out(o2r), .primed(p2r));
  moving_avg_filter #(.DATA_W(19), .LOG2_TAPS(2), .ROUND(0)) u_d4 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .data_in(data_in),
    .out_valid(v4), .data_out(o4), .primed(p4));
  moving_avg_filter #(.DATA_W(19), .LOG2_TAPS(3), .ROUND(0)) u_d8 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .data_in(data_in),
    .out_valid(v8), .data_out(o8), .primed(p8));

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then settle 1 time unit past the edge for sampling.
  task automatic step(input bit v, input int x, input bit clr);
    @(negedge clk);
    in_valid = v;
    data_in  = 19'(x);
    clear    = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    longint s;
    do_reset();
    chk("reset_valid", int'(v2), 0);
    chk("reset_data", int'(o2), 0);
    chk("reset_primed", int'(p2), 0);

    // 2-tap truncate, back-to-back
    step(1, 10, 0);
    chk("t1_v0", int'(v2), 1); chk("t1_d0", int'(o2), 5);  chk("t1_p0", int'(p2), 0);
    step(1, 20, 0);
    chk("t1_v1", int'(v2), 1); chk("t1_d1", int'(o2), 15); chk("t1_p1", int'(p2), 1);
    step(1, 30, 0);
    chk("t1_v2", int'(v2), 1); chk("t1_d2", int'(o2), 25); chk("t1_p2", int'(p2), 1);
    step(0, 0, 0);
    chk("t1_vdrop", int'(v2), 0);

    // Rounding of negative values
    do_reset();
    step(1, -3, 0);
    chk("t2_trunc0", int'(o2), -2); chk("t2_round0", int'(o2r), -1);
    step(1, -3, 0);
    chk("t2_trunc1", int'(o2), -3); chk("t2_round1", int'(o2r), -3);

    // 4-tap ramp with pointer wrap
    do_reset();
    step(1, 4, 0);  chk("t3_d0", int'(o4), 1);  chk("t3_p0", int'(p4), 0);
    step(1, 8, 0);  chk("t3_d1", int'(o4), 3);
    step(1, 12, 0); chk("t3_d2", int'(o4), 6);  chk("t3_p2", int'(p4), 0);
    step(1, 16, 0); chk("t3_d3", int'(o4), 10); chk("t3_p3", int'(p4), 1);
    step(1, 20, 0); chk("t3_d4", int'(o4), 14); chk("t3_v4", int'(v4), 1);

    // 8-tap extremes
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1, 262143, 0);
      s = (longint'(k) * 262143) >>> 3;
      chk($sformatf("t4_max%0d", k), int'(o8), int'(s));
    end
    chk("t4_primed", int'(p8), 1);
    for (int k = 1; k <= 8; k++) begin
      step(1, -262144, 0);
      s = (longint'(8 - k) * 262143 - longint'(k) * 262144) >>> 3;
      chk($sformatf("t4_min%0d", k), int'(o8), int'(s));
    end

    // Gaps and clear
    do_reset();
    step(1, 10, 0); chk("t5_d0", int'(o2), 5); chk("t5_v0", int'(v2), 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0);
      chk($sformatf("t5_idle_v%0d", k), int'(v2), 0);
      chk($sformatf("t5_idle_d%0d", k), int'(o2), 5);
    end
    step(1, 20, 0); chk("t5_d1", int'(o2), 15); chk("t5_p1", int'(p2), 1);
    step(1, 99, 1);
    chk("t5_clr_v", int'(v2), 0); chk("t5_clr_d", int'(o2), 15); chk("t5_clr_p", int'(p2), 0);
    step(1, 8, 0); chk("t5_d2", int'(o2), 4); chk("t5_p2", int'(p2), 0);

    // Asynchronous reset mid-stream
    step(1, 100, 0); chk("t6_pre", int'(o2), 54);
    rst = 1'b1;
    #1;
    chk("t6_rst_d", int'(o2), 0); chk("t6_rst_v", int'(v2), 0); chk("t6_rst_p", int'(p2), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 6, 0); chk("t6_d0", int'(o2), 3); chk("t6_v0", int'(v2), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
